// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: ALU writeback wins the port, and queued mult/div
// results drain on free cycles. The queue can be looked up so decode can forward from it.
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_wr,
    input  logic [4:0]    alu_addr,
    input  logic [31:0]   alu_data,
    input  logic          md_valid,
    input  logic [4:0]    md_addr,
    input  logic [31:0]   md_data,
    output logic          md_ready,
    output logic          rf_wr,
    output logic [4:0]    rf_addr,
    output logic [31:0]   rf_data,
    input  logic [4:0]    look_addr1,
    input  logic [4:0]    look_addr2,
    output logic          look_hit1,
    output logic          look_hit2,
    output logic [31:0]   look_data1,
    output logic [31:0]   look_data2,
    output logic [AW:0]   count
);

    logic [DEPTH-1:0] valid_q;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             alu_act;
    logic             pop;
    logic             push;
    logic             enq;
    logic [DEPTH-1:0] kill;

    assign alu_act  = alu_wr && (alu_addr != 5'd0);
    assign pop      = !alu_act && (count != '0);
    assign md_ready = reset && (count != (AW+1)'(DEPTH));
    assign push     = md_valid && md_ready;
    assign enq      = push && (md_addr != 5'd0);

    always_comb begin
        rf_wr   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (reset) begin
            if (alu_act) begin
                rf_wr   = 1'b1;
                rf_addr = alu_addr;
                rf_data = alu_data;
            end else if (count != '0) begin
                rf_wr   = valid_q[rd_ptr];
                rf_addr = addr_q[rd_ptr];
                rf_data = data_q[rd_ptr];
            end
        end
    end

    // Later writes to the same register invalidate queued ones; the popped slot is freed too.
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((alu_act && addr_q[i] == alu_addr) || (enq && addr_q[i] == md_addr))
                kill[i] = 1'b1;
        end
        if (pop)
            kill[rd_ptr] = 1'b1;
    end

    always_comb begin
        look_hit1  = 1'b0;
        look_hit2  = 1'b0;
        look_data1 = 32'd0;
        look_data2 = 32'd0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && look_addr1 != 5'd0 && addr_q[i] == look_addr1) begin
                    look_hit1  = 1'b1;
                    look_data1 = data_q[i];
                end
                if (valid_q[i] && look_addr2 != 5'd0 && addr_q[i] == look_addr2) begin
                    look_hit2  = 1'b1;
                    look_data2 = data_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            valid_q <= valid_q & ~kill;
            if (enq) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq && !pop)
                count <= count + 1'b1;
            else if (!enq && pop)
                count <= count - 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through valid bits.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= md_addr;
            data_q[wr_ptr] <= md_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a per-cycle vector table plus a reset-mid-drain sequence.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wr;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  look_addr1;
    logic [4:0]  look_addr2;
    logic        look_hit1;
    logic        look_hit2;
    logic [31:0] look_data1;
    logic [31:0] look_data2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .alu_wr(alu_wr), .alu_addr(alu_addr), .alu_data(alu_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
        .look_addr1(look_addr1), .look_addr2(look_addr2),
        .look_hit1(look_hit1), .look_hit2(look_hit2),
        .look_data1(look_data1), .look_data2(look_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        alu_wr;
        logic [4:0]  alu_addr;
        logic [31:0] alu_data;
        logic        md_valid;
        logic [4:0]  md_addr;
        logic [31:0] md_data;
        logic [4:0]  la1;
        logic [4:0]  la2;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
        logic [2:0]  e_count;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic aw, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic [4:0] l1, input logic [4:0] l2,
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic er, input logic [2:0] ec,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
        vec_t v;
        v.alu_wr = aw; v.alu_addr = aa; v.alu_data = ad;
        v.md_valid = mv; v.md_addr = ma; v.md_data = md;
        v.la1 = l1; v.la2 = l2;
        v.e_wr = ew; v.e_addr = ea; v.e_data = ed; v.e_ready = er; v.e_count = ec;
        v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] l1, input logic [4:0] l2);
        alu_wr = aw; alu_addr = aa; alu_data = ad;
        md_valid = mv; md_addr = ma; md_data = md;
        look_addr1 = l1; look_addr2 = l2;
    endtask

    initial begin
        // idle / single push / drain
        vecs.push_back(mk(0,0,0,     0,0,0,      0,0,   0,0,0,       1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,     1,8,'h11,   8,8,   0,0,0,       1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,     0,0,0,      8,8,   1,8,'h11,    1,1, 1,'h11,1,'h11));
        vecs.push_back(mk(0,0,0,     0,0,0,      8,8,   0,0,0,       1,0, 0,0,0,0));
        // ALU priority over queued results
        vecs.push_back(mk(1,3,'h100, 1,9,'hA,    9,10,  1,3,'h100,   1,0, 0,0,0,0));
        vecs.push_back(mk(1,3,'h101, 1,10,'hB,   9,10,  1,3,'h101,   1,1, 1,'hA,0,0));
        vecs.push_back(mk(1,3,'h102, 0,0,0,      9,10,  1,3,'h102,   1,2, 1,'hA,1,'hB));
        vecs.push_back(mk(0,0,0,     0,0,0,      9,10,  1,9,'hA,     1,2, 1,'hA,1,'hB));
        vecs.push_back(mk(0,0,0,     0,0,0,      9,10,  1,10,'hB,    1,1, 0,0,1,'hB));
        vecs.push_back(mk(0,0,0,     0,0,0,      9,10,  0,0,0,       1,0, 0,0,0,0));
        // fill to full, held-off push, pop while full does not admit
        vecs.push_back(mk(1,1,'h200, 1,11,'hC1,  11,14, 1,1,'h200,   1,0, 0,0,0,0));
        vecs.push_back(mk(1,1,'h201, 1,12,'hC2,  11,14, 1,1,'h201,   1,1, 1,'hC1,0,0));
        vecs.push_back(mk(1,1,'h202, 1,13,'hC3,  11,14, 1,1,'h202,   1,2, 1,'hC1,0,0));
        vecs.push_back(mk(1,1,'h203, 1,14,'hC4,  11,14, 1,1,'h203,   1,3, 1,'hC1,0,0));
        vecs.push_back(mk(1,1,'h204, 1,15,'hC5,  11,14, 1,1,'h204,   0,4, 1,'hC1,1,'hC4));
        vecs.push_back(mk(0,0,0,     1,15,'hC5,  11,14, 1,11,'hC1,   0,4, 1,'hC1,1,'hC4));
        vecs.push_back(mk(0,0,0,     1,15,'hC5,  11,14, 1,12,'hC2,   1,3, 0,0,1,'hC4));
        vecs.push_back(mk(0,0,0,     0,0,0,      15,14, 1,13,'hC3,   1,3, 1,'hC5,1,'hC4));
        vecs.push_back(mk(0,0,0,     0,0,0,      15,14, 1,14,'hC4,   1,2, 1,'hC5,1,'hC4));
        vecs.push_back(mk(0,0,0,     0,0,0,      15,14, 1,15,'hC5,   1,1, 1,'hC5,0,0));
        vecs.push_back(mk(0,0,0,     0,0,0,      15,14, 0,0,0,       1,0, 0,0,0,0));
        // ALU kills a queued entry
        vecs.push_back(mk(0,0,0,     1,5,'h55,   5,5,   0,0,0,       1,0, 0,0,0,0));
        vecs.push_back(mk(1,5,'h77,  0,0,0,      5,5,   1,5,'h77,    1,1, 1,'h55,1,'h55));
        vecs.push_back(mk(0,0,0,     0,0,0,      5,5,   0,5,'h55,    1,1, 0,0,0,0));
        vecs.push_back(mk(0,0,0,     0,0,0,      5,5,   0,0,0,       1,0, 0,0,0,0));
        // push kills older push; r0 push dropped
        vecs.push_back(mk(0,0,0,     1,6,'h1,    6,6,   0,0,0,       1,0, 0,0,0,0));
        vecs.push_back(mk(1,2,'h300, 1,6,'h2,    6,6,   1,2,'h300,   1,1, 1,'h1,1,'h1));
        vecs.push_back(mk(1,2,'h301, 1,0,'h99,   6,6,   1,2,'h301,   1,2, 1,'h2,1,'h2));
        vecs.push_back(mk(1,2,'h302, 0,0,0,      6,0,   1,2,'h302,   1,2, 1,'h2,0,0));
        vecs.push_back(mk(0,0,0,     0,0,0,      6,6,   0,6,'h1,     1,2, 1,'h2,1,'h2));
        vecs.push_back(mk(0,0,0,     0,0,0,      6,6,   1,6,'h2,     1,1, 1,'h2,1,'h2));
        vecs.push_back(mk(0,0,0,     0,0,0,      6,6,   0,0,0,       1,0, 0,0,0,0));
        // alu_wr to r0 is not an ALU write: queue drains
        vecs.push_back(mk(0,0,0,     1,7,'h70,   7,0,   0,0,0,       1,0, 0,0,0,0));
        vecs.push_back(mk(1,0,'hDEAD,0,0,0,      7,0,   1,7,'h70,    1,1, 1,'h70,0,0));
        vecs.push_back(mk(0,0,0,     0,0,0,      7,0,   0,0,0,       1,0, 0,0,0,0));

        // reset held: outputs forced even with requests present
        reset = 1'b0;
        drive(1, 3, 'h123, 1, 4, 'h456, 3, 4);
        #1;
        chk("rst_rf_wr", -1, 32'(rf_wr), 0);
        chk("rst_md_ready", -1, 32'(md_ready), 0);
        chk("rst_count", -1, 32'(count), 0);
        chk("rst_hit1", -1, 32'(look_hit1), 0);
        chk("rst_hit2", -1, 32'(look_hit2), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].alu_wr, vecs[i].alu_addr, vecs[i].alu_data,
                  vecs[i].md_valid, vecs[i].md_addr, vecs[i].md_data,
                  vecs[i].la1, vecs[i].la2);
            #1;
            chk("rf_wr", i, 32'(rf_wr), 32'(vecs[i].e_wr));
            if (vecs[i].e_wr || vecs[i].e_addr != 0) begin
                chk("rf_addr", i, 32'(rf_addr), 32'(vecs[i].e_addr));
                chk("rf_data", i, rf_data, vecs[i].e_data);
            end
            chk("md_ready", i, 32'(md_ready), 32'(vecs[i].e_ready));
            chk("count", i, 32'(count), 32'(vecs[i].e_count));
            chk("look_hit1", i, 32'(look_hit1), 32'(vecs[i].e_h1));
            chk("look_data1", i, look_data1, vecs[i].e_d1);
            chk("look_hit2", i, 32'(look_hit2), 32'(vecs[i].e_h2));
            chk("look_data2", i, look_data2, vecs[i].e_d2);
        end

        // reset mid-drain: three queued entries are discarded with no write
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 1, 32'h400 + 32'(k), 1, 5'(20 + k), 32'hE0 + 32'(k), 20, 22);
        end
        @(negedge clk);
        drive(1, 1, 'h403, 0, 0, 0, 20, 22);
        #1;
        chk("pre_rst_count", 100, 32'(count), 3);
        chk("pre_rst_hit2", 100, 32'(look_hit2), 1);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 20, 22);
        #1;
        chk("mid_rst_count", 101, 32'(count), 0);
        chk("mid_rst_rf_wr", 101, 32'(rf_wr), 0);
        chk("mid_rst_md_ready", 101, 32'(md_ready), 0);
        chk("mid_rst_hit1", 101, 32'(look_hit1), 0);
        chk("mid_rst_data2", 101, look_data2, 0);
        @(negedge clk);
        chk("mid_rst_rf_wr_hold", 102, 32'(rf_wr), 0);
        reset = 1'b1;
        #1;
        chk("post_rst_count", 103, 32'(count), 0);
        chk("post_rst_rf_wr", 103, 32'(rf_wr), 0);
        chk("post_rst_md_ready", 103, 32'(md_ready), 1);
        chk("post_rst_hit2", 103, 32'(look_hit2), 0);
        @(negedge clk);
        chk("post_rst_idle_rf_wr", 104, 32'(rf_wr), 0);
        chk("post_rst_idle_count", 104, 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
